// File: rtl/load_unit_pkg.sv
// Shared types and helpers for the load unit.
// LOAD_MISALIGN_TRAP_EN adds the FAULT state.
package load_unit_pkg;

  typedef enum logic [2:0] {
    LB, LH, LW, LD, LBU, LHU, LWU
  } load_ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
`ifdef LOAD_MISALIGN_TRAP_EN
    S_FAULT,
`endif
    S_WB
  } state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  // Doubling the word makes an offset shift wrap inside it.
  function automatic logic [63:0] extend_lane(
    input logic [63:0] data,
    input logic [2:0]  offset,
    input load_ctrl_e  ctrl,
    input logic        is64
  );
    logic [2:0]   off;
    logic [127:0] dbl;
    logic [127:0] sh;
    logic [63:0]  r;
    logic [63:0]  res;
    off = is64 ? offset : {1'b0, offset[1:0]};
    dbl = is64 ? {data, data}
               : {64'd0, data[31:0], data[31:0]};
    sh  = dbl >> {off, 3'b000};
    r   = sh[63:0];
    case (ctrl)
      LH:      res = {{48{r[15]}}, r[15:0]};
      LW:      res = {{32{r[31]}}, r[31:0]};
      LD:      res = r;
      LBU:     res = {56'd0, r[7:0]};
      LHU:     res = {48'd0, r[15:0]};
      LWU:     res = {32'd0, r[31:0]};
      default: res = {{56{r[7]}}, r[7:0]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_decode.sv
// Combinational load decoder: instruction bits [31:7]
// to rd, rs1 index, immediate and load control.
module load_decode
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0] instruction_code_i,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [11:0] imm_o,
  output load_ctrl_e  ctrl_o
);

  logic [2:0] f3;

  assign rd_o  = instruction_code_i[4:0];
  assign f3    = instruction_code_i[7:5];
  assign rs1_o = instruction_code_i[12:8];
  assign imm_o = instruction_code_i[24:13];

  always_comb begin
    ctrl_o = LB;
    unique case (1'b1)
      (f3 == F3_LH):  ctrl_o = LH;
      (f3 == F3_LW):  ctrl_o = LW;
      (f3 == F3_LBU): ctrl_o = LBU;
      (f3 == F3_LHU): ctrl_o = LHU;
      (XLEN == 64 && f3 == F3_LD):  ctrl_o = LD;
      (XLEN == 64 && f3 == F3_LWU): ctrl_o = LWU;
      default:        ctrl_o = LB;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Sequential load unit: decode, request, align, writeback.
// LOAD_MISALIGN_TRAP_EN traps misaligned accesses.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [24:0]       instruction_code,
  input  logic [XLEN-1:0]   rs1_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data
`ifdef LOAD_MISALIGN_TRAP_EN
  ,
  output logic              misalign_valid,
  output logic [ADDR_W-1:0] misalign_addr
`endif
);

  localparam int OFF_W = $clog2(XLEN / 8);

  state_e            state_q, state_d;
  logic [4:0]        rd_q, wb_rd_q;
  load_ctrl_e        ctrl_q;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [XLEN-1:0]   wb_data_q;

  logic [4:0]        dec_rd;
  logic [4:0]        dec_rs1;
  logic [11:0]       dec_imm;
  load_ctrl_e        dec_ctrl;
  logic [XLEN-1:0]   sum;
  logic [63:0]       rsp64;
  logic [2:0]        off3;
  logic [63:0]       lane;
  logic              accept;
  logic              mis;

  load_decode #(.XLEN(XLEN)) u_dec (
    .instruction_code_i(instruction_code),
    .rd_o              (dec_rd),
    .rs1_o             (dec_rs1),
    .imm_o             (dec_imm),
    .ctrl_o            (dec_ctrl)
  );

  assign sum    = rs1_data + {{(XLEN-12){dec_imm[11]}}, dec_imm};
  assign ea_d   = sum[ADDR_W-1:0];
  assign accept = (state_q == S_IDLE) && inst_valid;

`ifdef LOAD_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    case (dec_ctrl)
      LH, LHU: mis = ea_d[0];
      LW, LWU: mis = |ea_d[1:0];
      LD:      mis = |ea_d[2:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    rsp64 = '0;
    rsp64[XLEN-1:0] = mem_rsp_data;
    off3 = '0;
    off3[OFF_W-1:0] = ea_q[OFF_W-1:0];
    lane = extend_lane(rsp64, off3, ctrl_q, XLEN == 64);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (inst_valid)
                state_d = mis ? state_e'(S_IDLE + 3'd0) : S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_rsp_valid) state_d = S_WB;
      S_WB:   if (wb_ready) state_d = S_IDLE;
`ifdef LOAD_MISALIGN_TRAP_EN
      S_FAULT: if (wb_ready) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef LOAD_MISALIGN_TRAP_EN
    if (accept && mis) state_d = S_FAULT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      ctrl_q    <= LB;
      ea_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      if (accept) begin
        rd_q   <= dec_rd;
        ctrl_q <= dec_ctrl;
        ea_q   <= ea_d;
      end
      if (state_q == S_WAIT && mem_rsp_valid) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= lane[XLEN-1:0];
      end
    end
  end

  assign inst_ready    = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {ea_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign wb_valid      = (state_q == S_WB);
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misalign_valid = (state_q == S_FAULT);
  assign misalign_addr  = misalign_valid ? ea_q : '0;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Lockstep bench for load_unit at XLEN=32 and XLEN=64.
// Honours LOAD_MISALIGN_TRAP_EN when defined.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [24:0] ic = '0;
  logic [63:0] rs1 = '0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp = '0;
  logic        wb_ready = 1'b0;

  logic        ir32, rv32, wv32;
  logic [31:0] ra32, wd32;
  logic [4:0]  wr32;
  logic        ir64, rv64, wv64;
  logic [31:0] ra64;
  logic [63:0] wd64;
  logic [4:0]  wr64;
`ifdef LOAD_MISALIGN_TRAP_EN
  logic        mv32, mv64;
  logic [31:0] ma32, ma64;
`endif

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  load_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(ir32),
    .instruction_code(ic), .rs1_data(rs1[31:0]),
    .mem_req_valid(rv32), .mem_req_ready(req_ready),
    .mem_req_addr(ra32),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp[31:0]),
    .wb_valid(wv32), .wb_ready(wb_ready),
    .wb_rd(wr32), .wb_data(wd32)
`ifdef LOAD_MISALIGN_TRAP_EN
    , .misalign_valid(mv32), .misalign_addr(ma32)
`endif
  );

  load_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(ir64),
    .instruction_code(ic), .rs1_data(rs1),
    .mem_req_valid(rv64), .mem_req_ready(req_ready),
    .mem_req_addr(ra64),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp),
    .wb_valid(wv64), .wb_ready(wb_ready),
    .wb_rd(wr64), .wb_data(wd64)
`ifdef LOAD_MISALIGN_TRAP_EN
    , .misalign_valid(mv64), .misalign_addr(ma64)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: gather bytes one by one, wrapping within the word.
  function automatic logic [63:0] model(input int xl,
                                        input logic [2:0] f3,
                                        input logic [31:0] ea,
                                        input logic [63:0] word);
    int wbytes;
    int nb;
    bit sgn;
    int off;
    logic [63:0] v;
    wbytes = xl / 8;
    off = int'(ea % wbytes);
    nb = 1;
    sgn = 1;
    case (f3)
      3'd1: begin nb = 2; sgn = 1; end
      3'd2: begin nb = 4; sgn = (xl == 64); end
      3'd3: if (xl == 64) begin nb = 8; sgn = 1; end
      3'd4: begin nb = 1; sgn = 0; end
      3'd5: begin nb = 2; sgn = 0; end
      3'd6: if (xl == 64) begin nb = 4; sgn = 0; end
      default: begin nb = 1; sgn = 1; end
    endcase
    v = '0;
    for (int i = 0; i < nb; i++)
      v[i*8 +: 8] = word[((off + i) % wbytes)*8 +: 8];
    if (sgn && v[nb*8-1])
      for (int b = nb*8; b < 64; b++) v[b] = 1'b1;
    if (xl == 32) v[63:32] = '0;
    return v;
  endfunction

  task automatic do_load(input logic [2:0]  f3,
                         input logic [4:0]  rd,
                         input logic [11:0] imm,
                         input logic [63:0] rs1v,
                         input logic [63:0] rspv,
                         input int          rq_st,
                         input int          wb_st);
    logic [31:0] ea;
    logic [63:0] e32, e64;
    ea  = rs1v[31:0] + {{20{imm[11]}}, imm};
    e32 = model(32, f3, ea, {32'd0, rspv[31:0]});
    e64 = model(64, f3, ea, rspv);
    chk("idle_rdy32", ir32, 1'b1);
    chk("idle_rdy64", ir64, 1'b1);
    inst_valid = 1'b1;
    ic  = {imm, 5'd3, f3, rd};
    rs1 = rs1v;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    ic  = 25'($urandom);
    rs1 = {$urandom, $urandom};
    for (int i = 0; i <= rq_st; i++) begin
      chk("req_v32", rv32, 1'b1);
      chk("req_a32", ra32, ea & ~32'd3);
      chk("req_v64", rv64, 1'b1);
      chk("req_a64", ra64, ea & ~32'd7);
      chk("busy_rdy", {ir32, ir64}, 2'b00);
      req_ready = (i == rq_st);
      @(posedge clk); #1;
    end
    req_ready = 1'b0;
    chk("wait_noreq", {rv32, rv64}, 2'b00);
    rsp_valid = 1'b1;
    rsp = rspv;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    rsp = {$urandom, $urandom};
    for (int i = 0; i <= wb_st; i++) begin
      chk("wb_v", {wv32, wv64}, 2'b11);
      chk("wb_d32", {32'd0, wd32}, e32);
      chk("wb_d64", wd64, e64);
      chk("wb_rd", {wr32, wr64}, {rd, rd});
      chk("wb_noreq", {rv32, rv64}, 2'b00);
      wb_ready = (i == wb_st);
      @(posedge clk); #1;
    end
    wb_ready = 1'b0;
    chk("wb_done", {wv32, wv64, ir32, ir64}, 4'b0011);
  endtask

  initial begin
    logic [11:0] imm;
    logic [63:0] r1;
    #2;
    chk("rst_rdy", {ir32, ir64}, 2'b11);
    chk("rst_v", {rv32, rv64, wv32, wv64}, 4'b0000);
    chk("rst_d", {wd32, wd64[31:0]}, 64'd0);
    chk("rst_a", {ra32, ra64}, 64'd0);
    chk("rst_rd", {wr32, wr64}, 10'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(3'd0, 5'd7, 12'h003, 64'h1000,
            64'h80FF_1234, 0, 0);
    do_load(3'd5, 5'd9, 12'h002, 64'h1000,
            64'h8001_0000, 0, 0);
    do_load(3'd1, 5'd9, 12'h002, 64'h1000,
            64'h8001_0000, 3, 2);
    do_load(3'd2, 5'd0, 12'hFFC, 64'h2000,
            64'h1234_5678_8765_4321, 0, 0);
    do_load(3'd6, 5'd12, 12'h004, 64'h3000,
            64'hDEAD_BEEF_0000_0000, 1, 1);
    do_load(3'd3, 5'd13, 12'h008, 64'h3000,
            64'h8123_4567_89AB_CDEF, 0, 0);

`ifdef LOAD_MISALIGN_TRAP_EN
    inst_valid = 1'b1;
    ic  = {12'h001, 5'd3, 3'd2, 5'd4};
    rs1 = 64'h1000;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mis_v", {mv32, mv64}, 2'b11);
      chk("mis_a", {ma32, ma64}, {32'h1001, 32'h1001});
      chk("mis_noreq", {rv32, rv64, wv32, wv64}, 4'b0000);
      wb_ready = (i == 1);
      @(posedge clk); #1;
    end
    wb_ready = 1'b0;
    chk("mis_done", {mv32, mv64, ir32, ir64}, 4'b0011);
`else
    do_load(3'd2, 5'd4, 12'h001, 64'h1000,
            64'h4433_2211, 0, 0);
`endif

    // Reset abandons a transaction sitting in WAIT.
    inst_valid = 1'b1;
    ic  = {12'h000, 5'd3, 3'd2, 5'd5};
    rs1 = 64'h4000;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    rsp = 64'h5555_AAAA;
    rsp_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_v", {rv32, rv64, wv32, wv64}, 4'b0000);
    chk("arst_rdy", {ir32, ir64}, 2'b11);
    chk("arst_d", {wd32, wd64[31:0], ra32, ra64}, 128'd0);
    chk("arst_rd", {wr32, wr64}, 10'd0);
    rsp_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    chk("late_rsp", {wv32, wv64, ir32, ir64}, 4'b0011);
    chk("late_d", {wd32, wd64[31:0]}, 64'd0);
    do_load(3'd4, 5'd21, 12'h7FF, 64'h1,
            64'h0123_4567_89AB_CDEF, 0, 0);

    for (int n = 0; n < 24; n++) begin
      imm = 12'($urandom);
      r1  = {$urandom, $urandom};
`ifdef LOAD_MISALIGN_TRAP_EN
      imm = imm & ~12'h7;
      r1  = r1 & ~64'h7;
`endif
      do_load(3'($urandom), 5'($urandom), imm, r1,
              {$urandom, $urandom},
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Parametrised, sequential successor to the combinational load decoder.
- Accepts one load instruction per transaction and decodes rd/rs1/imm/func3.
- Computes the effective address, issues a valid/ready memory read, then aligns and sign/zero-extends the returned data.
- Presents the result on a valid/ready writeback port. Sits between the issue stage and the data-memory port of the core.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, memory address width; ADDR_W <= XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst_valid  input  1  load instruction presented.
- inst_ready  output  1  unit can accept an instruction (high only in IDLE).
- instruction_code  input  25  instruction bits [31:7].
- rs1_data  input  XLEN  base register value, sampled with the instruction.
- mem_req_valid  output  1  read request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  ADDR_W  word-aligned request address.
- mem_rsp_valid  input  1  read data valid (one pulse per request).
- mem_rsp_data  input  XLEN  full aligned word/doubleword.
- wb_valid  output  1  writeback result valid.
- wb_ready  input  1  register file accepts result.
- wb_rd  output  5  destination register.
- wb_data  output  XLEN  extended load result.
- misalign_valid  output  1  misaligned-access exception (present only with the optional feature).
- misalign_addr  output  ADDR_W  faulting effective address (present only with the optional feature).

Behaviour:
- Reset: async assertion of rst_n low forces the following, regardless of state:
  - state=IDLE
  - inst_ready=1
  - mem_req_valid=0, wb_valid=0, misalign_valid=0
  - wb_rd=0, wb_data=0, mem_req_addr=0, misalign_addr=0
  - Any outstanding transaction is abandoned. A mem_rsp_valid arriving in IDLE after reset is ignored.
- FSM states: IDLE -> REQ -> WAIT -> WB -> IDLE; optional FAULT state.
- IDLE:
  - inst_ready=1.
  - On inst_valid, latch rd=[11:7], func3=[14:12], imm=[31:20], and ea = rs1_data + sign-extended imm (truncated to ADDR_W).
  - Go to REQ (or FAULT, see optional feature).
- REQ:
  - mem_req_valid=1; mem_req_addr = ea with the low log2(XLEN/8) bits cleared.
  - Address must stay stable while valid is high and ready is low.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid, extract the lane at byte offset ea[log2(XLEN/8)-1:0] and extend it.
  - Register the result into wb_data/wb_rd; go to WB.
- WB:
  - wb_valid=1; hold wb_data/wb_rd stable until wb_ready, then go to IDLE.
  - rd=0 is still written back; the register file discards it.
- Latency: accept at cycle 0 -> mem_req_valid at cycle 1. Response sampled at cycle N -> wb_valid at cycle N+1. One transaction in flight at a time.
- func3 decode:
  - 0=LB (sign, 8b)
  - 1=LH (sign, 16b)
  - 2=LW (sign when XLEN=64, 32b)
  - 4=LBU, 5=LHU (zero-extend)
  - XLEN=64 only: 3=LD, 6=LWU
  - All other codes decode as LB.
- Misaligned without the optional feature: access proceeds. Bytes wrap modulo the XLEN/8-byte word (the offset is taken mod word size). Deterministic; no exception.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a misaligned access goes to FAULT instead of REQ. Misaligned means LH/LHU with ea[0]!=0, LW/LWU with ea[1:0]!=0, or LD with ea[2:0]!=0.
  - No memory request is issued.
  - FAULT holds misalign_valid=1 and misalign_addr=ea until wb_ready, then returns to IDLE. wb_valid stays 0.
- Undefined: misalign ports, FAULT state and the check are absent; wrap behaviour applies.

Decomposition:
- Package load_unit_pkg:
  - enum load_ctrl_e {LB, LH, LW, LD, LBU, LHU, LWU}
  - FSM state enum
  - func3 constants
  - function extend_lane(data, offset, ctrl)
- Sub-module load_decode: combinational instruction_code -> rd, rs1 index, imm, load_ctrl_e, parametrised by XLEN. It replaces the old decoder.

Test Plan:
- XLEN=32, LB: rs1_data=0x1000, imm=0x003, mem_rsp_data=0x80FF_1234 -> mem_req_addr=0x1000, wb_data=0xFFFF_FF80, wb_rd as encoded.
- LHU: ea=0x1002, rsp=0x8001_0000 -> wb_data=0x0000_8001. Same with LH -> 0xFFFF_8001.
- Backpressure: mem_req_ready low 3 cycles, wb_ready low 2 cycles -> mem_req_addr and wb_data stable; inst_ready=0 throughout; exactly one request issued.
- Negative imm: rs1_data=0x2000, imm=0xFFC, LW -> mem_req_addr=0x1FFC. XLEN=64, LWU with rsp upper word 0xDEAD_BEEF -> wb_data=0x0000_0000_DEAD_BEEF.
- Misaligned LW at ea=0x1001, rsp=0x4433_2211: with LOAD_MISALIGN_TRAP_EN -> misalign_valid=1, misalign_addr=0x1001, no mem_req_valid. Without -> wb_data=0x1144_3322.
- rst_n pulsed low during WAIT -> all outputs zero immediately; a late mem_rsp_valid is ignored; the next instruction completes normally.
